ofmap_maxpool: RTL and testbench

- Downstream consumer of the GEMM output BRAM (mem2). It runs after GEMM asserts finish_o.
- It reads the 14x14x64 ofmap through mem2 port 1 and applies a 2x2, stride-2 unsigned max-pool.
- It writes the 7x7x64 result into a new pooled-output BRAM (mem3).
- It replaces the testbench readout of mem2 as the next pipeline stage.

---
 rtl/ofmap_maxpool.sv | 134 +++++++++++++
 tb/tb_ofmap_maxpool.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ofmap_maxpool.sv
// 2x2 stride-2 unsigned max-pool from the GEMM ofmap BRAM (mem2) into the pooled BRAM (mem3).
// Each output word costs three cycles: read the top row, read the bottom row, then write.
module ofmap_maxpool #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned LANES          = 14,
  parameter int unsigned FMAP_H         = 14,
  parameter int unsigned OUT_CH         = 64,
  parameter int unsigned IN_ADDR_WIDTH  = 10,
  parameter int unsigned OUT_DATA_WIDTH = 56,
  parameter int unsigned OUT_ADDR_WIDTH = 9
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  output logic                          mem2_ce1,
  output logic                          mem2_we1,
  output logic [IN_ADDR_WIDTH-1:0]      mem2_addr1,
  input  logic [DATA_WIDTH*LANES-1:0]   mem2_q1_i,
  output logic                          mem3_ce0,
  output logic                          mem3_we0,
  output logic [OUT_ADDR_WIDTH-1:0]     mem3_addr0,
  output logic [OUT_DATA_WIDTH-1:0]     mem3_d0,
  output logic                          finish_o
);

  localparam int unsigned IN_W      = DATA_WIDTH * LANES;
  localparam int unsigned OUT_LANES = LANES / 2;
  localparam int unsigned ROWS_OUT  = FMAP_H / 2;
  localparam int unsigned R_W       = $clog2(ROWS_OUT);
  localparam int unsigned CH_W      = $clog2(OUT_CH);

  typedef enum logic [2:0] {IDLE, RD_TOP, RD_BOT, WR, DONE} state_t;

  state_t                    state, state_nx;
  logic [IN_ADDR_WIDTH-1:0]  rd_addr;
  logic [OUT_ADDR_WIDTH-1:0] wr_addr;
  logic [R_W-1:0]            r;
  logic [CH_W-1:0]           ch;
  logic [IN_W-1:0]           top_q;
  logic [OUT_DATA_WIDTH-1:0] pooled;
  logic [DATA_WIDTH-1:0]     max_top, max_bot;
  logic                      last_word;

  assign last_word = (ch == CH_W'(OUT_CH - 1)) && (r == R_W'(ROWS_OUT - 1));
  assign mem2_we1  = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Rows of one channel are contiguous and channels are back to back, so the
  // top-row address always advances by 2 per output, even across channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      wr_addr <= '0;
      r       <= '0;
      ch      <= '0;
      top_q   <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          rd_addr <= '0;
          wr_addr <= '0;
          r       <= '0;
          ch      <= '0;
        end
        RD_BOT: top_q <= mem2_q1_i;
        WR: begin
          rd_addr <= rd_addr + IN_ADDR_WIDTH'(2);
          wr_addr <= wr_addr + OUT_ADDR_WIDTH'(1);
          if (r == R_W'(ROWS_OUT - 1)) begin
            r  <= '0;
            ch <= ch + CH_W'(1);
          end else begin
            r <= r + R_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pooled  = '0;
    max_top = '0;
    max_bot = '0;
    for (int unsigned j = 0; j < OUT_LANES; j++) begin
      max_top = (top_q[IN_W-1-2*j*DATA_WIDTH -: DATA_WIDTH] > top_q[IN_W-1-(2*j+1)*DATA_WIDTH -: DATA_WIDTH])
              ? top_q[IN_W-1-2*j*DATA_WIDTH -: DATA_WIDTH] : top_q[IN_W-1-(2*j+1)*DATA_WIDTH -: DATA_WIDTH];
      max_bot = (mem2_q1_i[IN_W-1-2*j*DATA_WIDTH -: DATA_WIDTH] > mem2_q1_i[IN_W-1-(2*j+1)*DATA_WIDTH -: DATA_WIDTH])
              ? mem2_q1_i[IN_W-1-2*j*DATA_WIDTH -: DATA_WIDTH] : mem2_q1_i[IN_W-1-(2*j+1)*DATA_WIDTH -: DATA_WIDTH];
      pooled[OUT_DATA_WIDTH-1-j*DATA_WIDTH -: DATA_WIDTH] = (max_top > max_bot) ? max_top : max_bot;
    end
  end

  always_comb begin
    state_nx   = state;
    mem2_ce1   = 1'b0;
    mem2_addr1 = '0;
    mem3_ce0   = 1'b0;
    mem3_we0   = 1'b0;
    mem3_addr0 = '0;
    mem3_d0    = '0;
    finish_o   = 1'b0;
    case (state)
      IDLE: if (start_i) state_nx = RD_TOP;
      RD_TOP: begin
        mem2_ce1   = 1'b1;
        mem2_addr1 = rd_addr;
        state_nx   = RD_BOT;
      end
      RD_BOT: begin
        mem2_ce1   = 1'b1;
        mem2_addr1 = rd_addr + IN_ADDR_WIDTH'(1);
        state_nx   = WR;
      end
      WR: begin
        mem3_ce0   = 1'b1;
        mem3_we0   = 1'b1;
        mem3_addr0 = wr_addr;
        mem3_d0    = pooled;
        state_nx   = last_word ? DONE : RD_TOP;
      end
      DONE: begin
        finish_o = 1'b1;
        if (!start_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ofmap_maxpool.sv
// Scoreboard bench for ofmap_maxpool: a behavioural mem2 feeds the DUT, expected mem3 writes
// are queued when a run is launched and matched against every observed write.
module tb_ofmap_maxpool;

  localparam int NIN  = 896;
  localparam int NOUT = 448;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic         mem2_ce1, mem2_we1, mem3_ce0, mem3_we0, finish_o;
  logic [9:0]   mem2_addr1;
  logic [111:0] mem2_q1_i = '0;
  logic [8:0]   mem3_addr0;
  logic [55:0]  mem3_d0;

  typedef struct packed {logic [8:0] addr; logic [55:0] data;} wr_t;

  logic [111:0] mem2_m [0:NIN-1];
  logic [55:0]  mem3_m [0:NOUT-1];
  wr_t          exp_q[$];
  wr_t          obs_q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  logic [9:0]   last_rd = '0, prev_rd = '0;
  logic         we1_seen = 1'b0;

  ofmap_maxpool #(.DATA_WIDTH(8), .LANES(14), .FMAP_H(14), .OUT_CH(64),
                  .IN_ADDR_WIDTH(10), .OUT_DATA_WIDTH(56), .OUT_ADDR_WIDTH(9)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .mem2_ce1(mem2_ce1), .mem2_we1(mem2_we1), .mem2_addr1(mem2_addr1), .mem2_q1_i(mem2_q1_i),
    .mem3_ce0(mem3_ce0), .mem3_we0(mem3_we0), .mem3_addr0(mem3_addr0), .mem3_d0(mem3_d0),
    .finish_o(finish_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem2_ce1) begin
      mem2_q1_i <= mem2_m[mem2_addr1];
      prev_rd   <= last_rd;
      last_rd   <= mem2_addr1;
    end
  end

  always @(negedge clk) begin
    if (mem2_we1) we1_seen = 1'b1;
    if (mem3_ce0 && mem3_we0) begin
      obs_q.push_back('{addr: mem3_addr0, data: mem3_d0});
      mem3_m[mem3_addr0] = mem3_d0;
    end
  end

  function automatic logic [55:0] pool_ref(input logic [111:0] t, input logic [111:0] b);
    logic [55:0] res;
    logic [7:0]  m, x;
    res = '0;
    for (int j = 0; j < 7; j++) begin
      m = 8'd0;
      for (int k = 0; k < 2; k++) begin
        x = 8'(t >> ((13 - (2*j + k)) * 8)); if (x > m) m = x;
        x = 8'(b >> ((13 - (2*j + k)) * 8)); if (x > m) m = x;
      end
      res = (res << 8) | 56'(m);
    end
    return res;
  endfunction

  task automatic push_expected();
    int a;
    exp_q.delete();
    for (int c = 0; c < 64; c++)
      for (int r = 0; r < 7; r++) begin
        a = c*14 + 2*r;
        exp_q.push_back('{addr: 9'(c*7 + r), data: pool_ref(mem2_m[a], mem2_m[a+1])});
      end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NIN; i++)
      mem2_m[i] = {$urandom, $urandom, $urandom, 16'($urandom)};
  endtask

  // Raises start_i, drops it after drop_after cycles (0 = keep high), waits for finish_o.
  task automatic run_start(input int drop_after, output int elapsed, output bit timed_out);
    int s, n;
    obs_q.delete();
    @(negedge clk);
    start_i = 1'b1;
    s = cyc + 1;
    n = 0;
    timed_out = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (drop_after > 0 && n == drop_after) start_i = 1'b0;
      if (n > 3000) timed_out = 1'b1;
    end while (!finish_o && !timed_out);
    elapsed = cyc - s;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if ({mem2_ce1, mem2_we1, mem2_addr1, mem3_ce0, mem3_we0, mem3_addr0, mem3_d0, finish_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ce1=%b we1=%b a1=%h ce0=%b we0=%b a0=%h d0=%h fin=%b want all 0",
               mem2_ce1, mem2_we1, mem2_addr1, mem3_ce0, mem3_we0, mem3_addr0, mem3_d0, finish_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_run();
    int el; bit to; wr_t e, o;
    for (int i = 0; i < NIN; i++) mem2_m[i] = '0;
    push_expected();
    run_start(1, el, to);
    total++;
    if (to || el !== 1344) begin bad++; $display("FAIL zero_finish_latency: got %0d timeout=%0b want 1344", el, to); end
    total++;
    if (obs_q.size() !== NOUT) begin bad++; $display("FAIL zero_write_count: got %0d want %0d", obs_q.size(), NOUT); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL zero_word: got a=%0d d=%h want a=%0d d=%h", o.addr, o.data, e.addr, e.data); end
    end
  endtask

  task automatic test_pattern();
    int el; bit to; wr_t e, o;
    logic [111:0] w0, w1, w12, w13;
    fill_random();
    w0 = '0; w1 = '0; w12 = '0; w13 = '0;
    for (int k = 0; k < 14; k++) begin
      w0  = (w0 << 8) | 112'(k);
      w1  = (w1 << 8) | 112'(100 + k);
      w12 = (w12 << 8) | 112'((k == 0) ? 8'h80 : 8'h7F);
      w13 = (w13 << 8) | 112'((k == 5) ? 8'hFF : 8'h7F);
    end
    mem2_m[0] = w0; mem2_m[1] = w1; mem2_m[894] = w12; mem2_m[895] = w13;
    push_expected();
    run_start(1, el, to);
    total++;
    if (to || el !== 1344) begin bad++; $display("FAIL pattern_finish_latency: got %0d timeout=%0b want 1344", el, to); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL pattern_word: got a=%0d d=%h want a=%0d d=%h", o.addr, o.data, e.addr, e.data); end
    end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL pattern_missing_writes: got %0d left want 0", exp_q.size()); end
    total++;
    if (mem3_m[0] !== 56'h65676_96B6D6F71) begin bad++; $display("FAIL pattern_mem3_0: got %h want 6567696b6d6f71", mem3_m[0]); end
    total++;
    if (mem3_m[447] !== 56'h807FFF7F7F7F7F) begin bad++; $display("FAIL pattern_mem3_447: got %h want 807fff7f7f7f7f", mem3_m[447]); end
    total++;
    if (prev_rd !== 10'd894 || last_rd !== 10'd895) begin bad++; $display("FAIL pattern_last_reads: got %0d/%0d want 894/895", prev_rd, last_rd); end
    total++;
    if (we1_seen !== 1'b0) begin bad++; $display("FAIL mem2_we1_const: got 1 want 0"); end
  endtask

  task automatic test_reset_midrun();
    int n, el; bit to; wr_t e, o;
    fill_random();
    obs_q.delete();
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (obs_q.size() < 200 && n < 1000);
    total++;
    if (obs_q.size() !== 200 || !mem3_we0) begin bad++; $display("FAIL midrun_reach_200: got %0d writes we0=%b want 200 and 1", obs_q.size(), mem3_we0); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({mem2_ce1, mem2_addr1, mem3_ce0, mem3_we0, mem3_addr0, mem3_d0, finish_o} !== '0) begin
      bad++; $display("FAIL midrun_reset_outputs: got ce1=%b ce0=%b we0=%b a0=%h d0=%h want all 0", mem2_ce1, mem3_ce0, mem3_we0, mem3_addr0, mem3_d0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if (obs_q.size() !== 200) begin bad++; $display("FAIL midrun_no_more_writes: got %0d want 200", obs_q.size()); end
    push_expected();
    run_start(1, el, to);
    total++;
    if (to || el !== 1344) begin bad++; $display("FAIL rerun_finish_latency: got %0d timeout=%0b want 1344", el, to); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL rerun_word: got a=%0d d=%h want a=%0d d=%h", o.addr, o.data, e.addr, e.data); end
    end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL rerun_missing_writes: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_start_hold();
    int el; bit to, ok; wr_t e, o;
    fill_random();
    push_expected();
    run_start(0, el, to);
    total++;
    if (to || el !== 1344) begin bad++; $display("FAIL hold_finish_latency: got %0d timeout=%0b want 1344", el, to); end
    ok = 1'b1;
    repeat (20) begin @(negedge clk); if (finish_o !== 1'b1 || mem2_ce1 !== 1'b0 || mem3_we0 !== 1'b0) ok = 1'b0; end
    total++;
    if (ok !== 1'b1 || obs_q.size() !== NOUT) begin bad++; $display("FAIL hold_no_retrigger: got ok=%b writes=%0d want 1 and 448", ok, obs_q.size()); end
    start_i = 1'b0;
    @(negedge clk);
    total++;
    if (finish_o !== 1'b0) begin bad++; $display("FAIL hold_release_idle: got finish=%b want 0", finish_o); end
    fill_random();
    push_expected();
    run_start(1, el, to);
    total++;
    if (to || el !== 1344) begin bad++; $display("FAIL second_run_latency: got %0d timeout=%0b want 1344", el, to); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL second_run_word: got a=%0d d=%h want a=%0d d=%h", o.addr, o.data, e.addr, e.data); end
    end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL second_run_missing: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_start_drop();
    int el; bit to; wr_t e, o;
    fill_random();
    push_expected();
    run_start(10, el, to);
    total++;
    if (to || el !== 1344) begin bad++; $display("FAIL drop_finish_latency: got %0d timeout=%0b want 1344", el, to); end
    @(negedge clk);
    total++;
    if (finish_o !== 1'b0) begin bad++; $display("FAIL drop_finish_pulse: got finish=%b want 0", finish_o); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL drop_word: got a=%0d d=%h want a=%0d d=%h", o.addr, o.data, e.addr, e.data); end
    end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL drop_missing_writes: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_zero_run();
    test_pattern();
    test_reset_midrun();
    test_start_hold();
    test_start_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
